baby_store_loader: RTL and testbench



---
 rtl/baby_store_pkg.sv | 16 +
 rtl/baby_store_ram.sv | 55 +++++
 rtl/baby_store_loader.sv | 124 ++++++++++++
 tb/tb_baby_store_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/baby_store_pkg.sv
// Shared types and default geometry for the Manchester Baby main store and its loader.
package baby_store_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_ADDR_W     = 5;
  localparam int unsigned DEF_WORDS      = 32;
  localparam int unsigned BYTES_PER_WORD = DEF_DATA_W / 8;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/baby_store_ram.sv
// WORDS x DATA_W store: reset-clear, one synchronous write port muxed by owner, async read.
module baby_store_ram
  import baby_store_pkg::*;
#(
  parameter int unsigned WORDS  = DEF_WORDS,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_i,
  input  state_t            i_state,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  // The loader owns the store in LOAD, the core only in RUN; IDLE writes nothing.
  always_comb begin
    w_we   = 1'b0;
    w_addr = i_ld_addr;
    w_data = i_ld_data;
    case (i_state)
      LOAD: w_we = i_ld_we;
      RUN: begin
        w_we   = i_core_we;
        w_addr = i_core_addr;
        w_data = i_core_data;
      end
      default: w_we = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[w_addr] <= w_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/baby_store_loader.sv
// Main store for the Baby core plus a byte-serial loader that holds the core in reset while filling.
module baby_store_loader
  import baby_store_pkg::*;
#(
  parameter int unsigned WORDS  = DEF_WORDS,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic              load_start_i,
  input  logic [7:0]        load_byte_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              core_reset_o,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_data_i,
  input  logic              core_rw_en_i,
  output logic [DATA_W-1:0] core_data_o
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(LANES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [IDX_W-1:0]  w_byte_idx_nxt;
  logic [ADDR_W-1:0] r_word_addr;
  logic [ADDR_W-1:0] w_word_addr_nxt;
  logic [DATA_W-1:0] r_asm;
  logic [DATA_W-1:0] w_asm_nxt;
  logic [DATA_W-1:0] w_ld_wdata;
  logic              w_ld_we;
  logic              w_accept;

  assign load_ready_o = (r_state == LOAD);
  assign load_done_o  = (r_state == RUN);
  assign core_reset_o = (r_state != RUN);
  assign w_accept     = load_valid_i & load_ready_o;

  // Assembly register with the incoming byte dropped into its lane.
  always_comb begin
    w_ld_wdata = r_asm;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (r_byte_idx == IDX_W'(l)) begin
        w_ld_wdata[8*l +: 8] = load_byte_i;
      end
    end
  end

  // Next-state and loader counters; load_start_i beats a same-cycle byte.
  always_comb begin
    w_state_nxt     = r_state;
    w_byte_idx_nxt  = r_byte_idx;
    w_word_addr_nxt = r_word_addr;
    w_asm_nxt       = r_asm;
    w_ld_we         = 1'b0;
    case (r_state)
      IDLE, RUN: begin
        if (load_start_i) begin
          w_state_nxt     = LOAD;
          w_byte_idx_nxt  = '0;
          w_word_addr_nxt = '0;
          w_asm_nxt       = '0;
        end
      end
      LOAD: begin
        if (load_start_i) begin
          w_byte_idx_nxt  = '0;
          w_word_addr_nxt = '0;
          w_asm_nxt       = '0;
        end else if (w_accept) begin
          w_asm_nxt = w_ld_wdata;
          if (r_byte_idx == IDX_W'(LANES - 1)) begin
            w_ld_we         = 1'b1;
            w_byte_idx_nxt  = '0;
            w_word_addr_nxt = r_word_addr + ADDR_W'(1);
            if (r_word_addr == ADDR_W'(WORDS - 1)) begin
              w_state_nxt = RUN;
            end
          end else begin
            w_byte_idx_nxt = r_byte_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_byte_idx  <= '0;
      r_word_addr <= '0;
      r_asm       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_word_addr <= w_word_addr_nxt;
      r_asm       <= w_asm_nxt;
    end
  end

  baby_store_ram #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock       (clock),
    .reset_i     (reset_i),
    .i_state     (r_state),
    .i_ld_we     (w_ld_we),
    .i_ld_addr   (r_word_addr),
    .i_ld_data   (w_ld_wdata),
    .i_core_we   (core_rw_en_i),
    .i_core_addr (core_addr_i),
    .i_core_data (core_data_i),
    .i_rd_addr   (core_addr_i),
    .o_rd_data   (core_data_o)
  );

endmodule

// File: tb/tb_baby_store_loader.sv
// Directed/randomised bench for baby_store_loader against a byte-count based store model.
module tb_baby_store_loader;

  logic        clock = 1'b0;
  logic        reset_i;
  logic        load_start_i;
  logic [7:0]  load_byte_i;
  logic        load_valid_i;
  logic        load_ready_o;
  logic        load_done_o;
  logic        core_reset_o;
  logic [4:0]  core_addr_i;
  logic [31:0] core_data_i;
  logic        core_rw_en_i;
  logic [31:0] core_data_o;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 loading, 2 running; cnt = bytes taken since the last (re)start.
  logic [31:0] m_mem [32];
  logic [31:0] snap  [32];
  logic [31:0] m_part;
  int          m_mode;
  int          m_cnt;
  int          accepted;

  always #5 clock = ~clock;

  baby_store_loader dut (
    .clock        (clock),
    .reset_i      (reset_i),
    .load_start_i (load_start_i),
    .load_byte_i  (load_byte_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_done_o  (load_done_o),
    .core_reset_o (core_reset_o),
    .core_addr_i  (core_addr_i),
    .core_data_i  (core_data_i),
    .core_rw_en_i (core_rw_en_i),
    .core_data_o  (core_data_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pattern(input int n, input int b);
    case (b)
      0:       return 8'(n);
      1:       return 8'hA5;
      2:       return 8'h5A;
      default: return 8'hC3;
    endcase
  endfunction

  task automatic model_step();
    if (reset_i) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_mode = 0;
      m_cnt  = 0;
      m_part = '0;
    end else begin
      case (m_mode)
        0: if (load_start_i) begin
          m_mode = 1; m_cnt = 0; m_part = '0;
        end
        1: if (load_start_i) begin
          m_cnt = 0; m_part = '0;
        end else if (load_valid_i) begin
          m_part[8*(m_cnt%4) +: 8] = load_byte_i;
          m_cnt++;
          accepted++;
          if (m_cnt % 4 == 0) m_mem[m_cnt/4 - 1] = m_part;
          if (m_cnt == 128) begin
            m_mode = 2; m_cnt = 0;
          end
        end
        default: begin
          if (core_rw_en_i) m_mem[core_addr_i] = core_data_i;
          if (load_start_i) begin
            m_mode = 1; m_cnt = 0; m_part = '0;
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_ready"}, 32'(load_ready_o), 32'(m_mode == 1));
    chk({tag, "_done"},  32'(load_done_o),  32'(m_mode == 2));
    chk({tag, "_creset"}, 32'(core_reset_o), 32'(m_mode != 2));
  endtask

  // src: 0 = model, 1 = snapshot of the gapless load, 2 = all zero.
  task automatic scan(input string tag, input int src);
    logic [31:0] exp;
    load_start_i = 1'b0; load_valid_i = 1'b0; core_rw_en_i = 1'b0;
    for (int a = 0; a < 32; a++) begin
      core_addr_i = 5'(a);
      #1;
      exp = (src == 0) ? m_mem[a] : (src == 1) ? snap[a] : 32'h0;
      chk($sformatf("%s_mem%0d", tag, a), core_data_o, exp);
      tick();
    end
  endtask

  task automatic send(input logic [7:0] b);
    load_valid_i = 1'b1;
    load_byte_i  = b;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  bb [4];
    logic [31:0] exp_w;
    int          idx;

    reset_i = 1'b1; load_start_i = 1'b0; load_byte_i = 8'h00; load_valid_i = 1'b0;
    core_addr_i = '0; core_data_i = '0; core_rw_en_i = 1'b0;
    accepted = 0;
    tick(); tick();
    reset_i = 1'b0;
    chk_status("rst");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_status("idle");
    end
    scan("rst", 2);

    // Gapless load
    load_start_i = 1'b1; tick(); load_start_i = 1'b0;
    chk_status("ld_start");
    for (int n = 0; n < 32; n++) begin
      for (int b = 0; b < 4; b++) begin
        if (n == 31 && b == 3) chk("pre_done", 32'(load_done_o), 32'h0);
        send(pattern(n, b));
      end
    end
    load_valid_i = 1'b0;
    chk("done_rise", 32'(load_done_o), 32'h1);
    chk("creset_fall", 32'(core_reset_o), 32'h0);
    chk_status("gapless_end");
    core_addr_i = 5'd7;
    #1;
    chk("mem7_lanes", core_data_o, 32'hC35AA507);
    scan("gapless", 0);
    for (int i = 0; i < 32; i++) snap[i] = m_mem[i];

    // Random-valid load of the same image
    load_start_i = 1'b1; tick(); load_start_i = 1'b0;
    accepted = 0;
    idx = 0;
    for (int cyc = 0; cyc < 2000 && m_mode != 2; cyc++) begin
      chk_status("rnd");
      load_valid_i = 1'($urandom % 2);
      load_byte_i  = pattern(idx / 4, idx % 4);
      if (load_valid_i) idx++;
      tick();
    end
    load_valid_i = 1'b0;
    chk("rnd_done", 32'(load_done_o), 32'h1);
    chk("rnd_count", 32'(accepted), 32'd128);
    scan("rnd", 1);

    // Core write with read-during-write, then a read-only access
    core_addr_i = 5'd31; core_data_i = 32'hDEADBEEF; core_rw_en_i = 1'b1;
    #1;
    chk("rdw_old", core_data_o, snap[31]);
    tick();
    core_rw_en_i = 1'b0;
    #1;
    chk("rdw_new", core_data_o, 32'hDEADBEEF);
    core_addr_i = 5'd0; core_data_i = 32'h12345678; core_rw_en_i = 1'b0;
    tick();
    chk("rd_only", core_data_o, snap[0]);

    // Restart from RUN with a same-cycle core write, then abort mid-word
    core_addr_i = 5'd5; core_data_i = 32'hCAFEF00D; core_rw_en_i = 1'b1; load_start_i = 1'b1;
    tick();
    core_rw_en_i = 1'b0; load_start_i = 1'b0;
    chk_status("restart");
    chk("run_start_wr", core_data_o, 32'hCAFEF00D);
    for (int i = 0; i < 9; i++) send(8'($urandom));
    load_start_i = 1'b1; load_valid_i = 1'b1; load_byte_i = 8'hEE;
    tick();
    load_start_i = 1'b0;
    core_addr_i = 5'd2;
    #1;
    chk("abort_mem2", core_data_o, snap[2]);
    for (int i = 0; i < 4; i++) begin
      bb[i] = 8'($urandom);
      send(bb[i]);
    end
    load_valid_i = 1'b0;
    core_addr_i = 5'd0;
    #1;
    exp_w = {bb[3], bb[2], bb[1], bb[0]};
    chk("abort_word0", core_data_o, exp_w);
    for (int i = 0; i < 124; i++) send(8'($urandom));
    load_valid_i = 1'b0;
    chk_status("reload_end");
    scan("reload", 0);

    // Reset in the middle of a load
    load_start_i = 1'b1; tick(); load_start_i = 1'b0;
    for (int i = 0; i < 70; i++) send(8'($urandom));
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; load_valid_i = 1'b0;
    chk_status("midrst");
    chk("midrst_ready", 32'(load_ready_o), 32'h0);
    chk("midrst_creset", 32'(core_reset_o), 32'h1);
    for (int i = 0; i < 4; i++) begin
      core_addr_i = 5'($urandom); core_data_i = $urandom; core_rw_en_i = 1'b1;
      tick();
    end
    core_rw_en_i = 1'b0;
    scan("idle_wr", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
